serial_sge: RTL and testbench

Bit-serial signed greater-or-equal comparator with valid/ready handshakes on both sides. It is the sequential, area-reduced counterpart of the wrapped parallel signed compare primitives.
- Latches two signed operands, walks them LSB-first one bit per clock, and reports `I0 >= I1` (signed) plus equality.
- Used where a full-width combinational comparator is too costly and a few cycles of latency are acceptable.

---
 rtl/serial_sge.sv | 98 +++++++++
 tb/tb_serial_sge.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_sge.sv
// Bit-serial signed >= / == comparator, LSB-first, one bit per clock, valid/ready on both sides.
// Define SERIAL_SGE_B2B_EN to let DONE hand off a result and accept new operands on the same edge.
module serial_sge #(
  parameter int width = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [width-1:0] I0,
  input  logic [width-1:0] I1,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             O,
  output logic             EQ,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int CW = $clog2(width);
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [width-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             ge, eq;
  logic             accept, last_bit;
  logic             a, b;
  logic             ge_nxt, eq_nxt;

  assign a        = a_sr[0];
  assign b        = b_sr[0];
  assign last_bit = (cnt == LAST);
  assign accept   = valid_in & ready_out;

  // The sign bit carries inverted weight, so a mismatch there flips the verdict.
  assign ge_nxt = (a != b) ? (last_bit ? ~a : a) : ge;
  assign eq_nxt = eq & (a == b);

  always_comb begin
    ready_out = 1'b0;
    if (!RESET) begin
`ifdef SERIAL_SGE_B2B_EN
      ready_out = (state == IDLE) | ((state == DONE) & ready_in);
`else
      ready_out = (state == IDLE);
`endif
    end
  end

  assign valid_out = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = BUSY;
      BUSY: if (last_bit) state_nxt = DONE;
      DONE: if (ready_in) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_sr <= '0;
      b_sr <= '0;
      cnt  <= '0;
      ge   <= 1'b1;
      eq   <= 1'b1;
      O    <= 1'b0;
      EQ   <= 1'b0;
    end else if (accept) begin
      a_sr <= I0;
      b_sr <= I1;
      cnt  <= '0;
      ge   <= 1'b1;
      eq   <= 1'b1;
    end else if (state == BUSY) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      ge   <= ge_nxt;
      eq   <= eq_nxt;
      // Counter parks on the sign-bit index instead of wrapping.
      if (last_bit) begin
        O  <= ge_nxt;
        EQ <= eq_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_sge.sv
// Directed bench for serial_sge at width=4: compares, back-pressure, mid-op reset, issue spacing.
module tb_serial_sge;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [W-1:0] I0, I1;
  logic         valid_in, ready_in;
  logic         ready_out, O, EQ, valid_out;

  int n_cmp = 0;
  int n_err = 0;

  serial_sge #(.width(W)) dut (
    .CLK(CLK), .RESET(RESET), .I0(I0), .I1(I1),
    .valid_in(valid_in), .ready_out(ready_out),
    .O(O), .EQ(EQ), .valid_out(valid_out), .ready_in(ready_in)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one operand pair through accept and waits (bounded) for the result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic o, output logic e, output int lat);
    int w;
    I0 = a; I1 = b; valid_in = 1'b1;
    w = 0;
    while (!ready_out && w < 20) begin tick(); w++; end
    tick();
    valid_in = 1'b0;
    I0 = W'($urandom); I1 = W'($urandom);
    lat = 0;
    while (!valid_out && lat < 20) begin tick(); lat++; end
    o = O; e = EQ;
  endtask

  task automatic test_reset();
    RESET = 1'b1; valid_in = 1'b0; ready_in = 1'b1; I0 = '0; I1 = '0;
    tick(); tick();
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL rst_ready_out: got %b want 0", ready_out); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
    n_cmp++; if (O !== 1'b0) begin n_err++; $display("FAIL rst_O: got %b want 0", O); end
    n_cmp++; if (EQ !== 1'b0) begin n_err++; $display("FAIL rst_EQ: got %b want 0", EQ); end
    RESET = 1'b0;
    #1;
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_compare();
    logic [W-1:0] va [7] = '{4'b0111, 4'b1111, 4'b0000, 4'b0101, 4'b1000, 4'b1000, 4'b0011};
    logic [W-1:0] vb [7] = '{4'b1000, 4'b0000, 4'b1111, 4'b0101, 4'b1000, 4'b0111, 4'b0010};
    logic         xo [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic         xe [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic o, e;
    int lat;
    ready_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_op(va[i], vb[i], o, e, lat);
      n_cmp++; if (lat !== W) begin n_err++; $display("FAIL cmp%0d_latency: got %0d want %0d", i, lat, W); end
      n_cmp++; if (o !== xo[i]) begin n_err++; $display("FAIL cmp%0d_O: got %b want %b", i, o, xo[i]); end
      n_cmp++; if (e !== xe[i]) begin n_err++; $display("FAIL cmp%0d_EQ: got %b want %b", i, e, xe[i]); end
      tick();
      n_cmp++; if (ready_out !== 1'b1 || valid_out !== 1'b0)
        begin n_err++; $display("FAIL cmp%0d_idle: got rdy=%b vld=%b want rdy=1 vld=0", i, ready_out, valid_out); end
    end
  endtask

  task automatic test_backpressure();
    logic o, e;
    int lat;
    ready_in = 1'b0;
    do_op(4'b0010, 4'b0011, o, e, lat);
    n_cmp++; if (o !== 1'b0 || e !== 1'b0) begin n_err++; $display("FAIL bp_result: got O=%b EQ=%b want O=0 EQ=0", o, e); end
    for (int i = 0; i < 5; i++) begin
      valid_in = i[0]; I0 = 4'b0101; I1 = 4'b0101;
      #1;
      n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready_out%0d: got %b want 0", i, ready_out); end
      tick();
      n_cmp++; if (valid_out !== 1'b1 || O !== 1'b0 || EQ !== 1'b0)
        begin n_err++; $display("FAIL bp_hold%0d: got vld=%b O=%b EQ=%b want 1 0 0", i, valid_out, O, EQ); end
    end
    valid_in = 1'b0; ready_in = 1'b1;
    tick();
    n_cmp++; if (valid_out !== 1'b0 || ready_out !== 1'b1)
      begin n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", valid_out, ready_out); end
  endtask

  task automatic test_reset_mid_busy();
    logic o, e;
    int lat, seen;
    ready_in = 1'b1;
    do_op(4'b0101, 4'b0101, o, e, lat);
    tick();
    I0 = 4'b0111; I1 = 4'b1000; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick(); tick();
    RESET = 1'b1;
    #1;
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready_comb: got %b want 0", ready_out); end
    tick();
    n_cmp++; if (valid_out !== 1'b0 || O !== 1'b0 || EQ !== 1'b0 || ready_out !== 1'b0)
      begin n_err++; $display("FAIL mid_rst_outputs: got vld=%b O=%b EQ=%b rdy=%b want 0 0 0 0", valid_out, O, EQ, ready_out); end
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (valid_out) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_rst_no_result: got %0d results want 0", seen); end
    do_op(4'b1000, 4'b0111, o, e, lat);
    n_cmp++; if (o !== 1'b0 || e !== 1'b0 || lat !== W)
      begin n_err++; $display("FAIL mid_rst_fresh: got O=%b EQ=%b lat=%0d want 0 0 %0d", o, e, lat, W); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc, nres, pend, gap, w;
    int t [2];
    logic r [2];
`ifdef SERIAL_SGE_B2B_EN
    gap = W + 1;
`else
    gap = W + 2;
`endif
    acc = 0; nres = 0;
    t[0] = 0; t[1] = 0; r[0] = 1'bx; r[1] = 1'bx;
    ready_in = 1'b1; I0 = 4'd3; I1 = 4'd2; valid_in = 1'b1;
    for (int c = 0; c < 40 && nres < 2; c++) begin
      pend = int'(ready_out);
      tick();
      if (pend != 0) begin
        acc++;
        if (acc == 1) begin I0 = 4'd2; I1 = 4'd3; end
      end
      if (valid_out) begin t[nres] = c; r[nres] = O; nres++; end
    end
    valid_in = 1'b0;
    n_cmp++; if (nres !== 2) begin n_err++; $display("FAIL b2b_count: got %0d results want 2", nres); end
    n_cmp++; if (r[0] !== 1'b1) begin n_err++; $display("FAIL b2b_first_O: got %b want 1", r[0]); end
    n_cmp++; if (r[1] !== 1'b0) begin n_err++; $display("FAIL b2b_second_O: got %b want 0", r[1]); end
    n_cmp++; if (t[1] - t[0] !== gap) begin n_err++; $display("FAIL b2b_spacing: got %0d want %0d", t[1] - t[0], gap); end
    w = 0;
    while (!ready_out && w < 20) begin tick(); w++; end
  endtask

  initial begin
    test_reset();
    test_compare();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
